// File: rtl/alu_seq_nb.sv
// Registered WIDTH-bit ALU with valid/ready on both sides and {Z,N,C,V} flags.
// Define ALU_MUL_EN to add the multi-cycle shift-add MUL (opcode 1000) and the BUSY state.
`timescale 1ns/1ps
module alu_seq_nb #(
  parameter int WIDTH = 4
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  input  logic [3:0]       op,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [WIDTH-1:0] result,
  output logic [3:0]       flags,
  output logic             err
);
  localparam int SHW = $clog2(WIDTH);

`ifdef ALU_MUL_EN
  typedef enum logic [1:0] {IDLE, BUSY, DONE} state_t;
  localparam logic [SHW-1:0] LAST = SHW'(WIDTH-1);
  logic [2*WIDTH-1:0] mcand_q, mcand_d, acc_q, acc_d, acc_nxt;
  logic [WIDTH-1:0]   mplier_q, mplier_d;
  logic [SHW-1:0]     cnt_q, cnt_d;
`else
  typedef enum logic {IDLE, DONE} state_t;
`endif

  state_t           state_q, state_d;
  logic [WIDTH-1:0] result_q, result_d;
  logic [3:0]       flags_q, flags_d;
  logic             err_q, err_d;

  logic [WIDTH-1:0] alu_res;
  logic             alu_c, alu_v, alu_err, alu_mul, accept;
  logic [WIDTH:0]   sum_w, sh_r, sh_l;
  logic [SHW-1:0]   shamt;

  // Single-cycle datapath; shifts carry one guard bit so the last bit out lands in C.
  always_comb begin
    alu_res = '0;
    alu_c   = 1'b0;
    alu_v   = 1'b0;
    alu_err = 1'b0;
    alu_mul = 1'b0;
    shamt   = b[SHW-1:0];
    sum_w   = '0;
    sh_r    = '0;
    sh_l    = '0;
    case (op)
      4'h0: begin
        sum_w   = {1'b0, a} + {1'b0, b};
        alu_res = sum_w[WIDTH-1:0];
        alu_c   = sum_w[WIDTH];
        alu_v   = (a[WIDTH-1] == b[WIDTH-1]) && (sum_w[WIDTH-1] != a[WIDTH-1]);
      end
      4'h1: begin
        sum_w   = {1'b0, a} - {1'b0, b};
        alu_res = sum_w[WIDTH-1:0];
        alu_c   = sum_w[WIDTH];
        alu_v   = (a[WIDTH-1] != b[WIDTH-1]) && (sum_w[WIDTH-1] != a[WIDTH-1]);
      end
      4'h2: alu_res = a & b;
      4'h3: alu_res = a | b;
      4'h4: alu_res = a ^ b;
      4'h5: alu_res = ~a;
      4'h6: begin
        sh_r    = {a, 1'b0} >> shamt;
        alu_res = sh_r[WIDTH:1];
        alu_c   = sh_r[0];
      end
      4'h7: begin
        sh_l    = {1'b0, a} << shamt;
        alu_res = sh_l[WIDTH-1:0];
        alu_c   = sh_l[WIDTH];
      end
`ifdef ALU_MUL_EN
      4'h8: alu_mul = 1'b1;
`endif
      default: alu_err = 1'b1;
    endcase
  end

  always_comb begin
    state_d  = state_q;
    result_d = result_q;
    flags_d  = flags_q;
    err_d    = err_q;
    in_ready = (state_q == IDLE) || ((state_q == DONE) && out_ready);
    accept   = in_valid && in_ready;
`ifdef ALU_MUL_EN
    mcand_d  = mcand_q;
    mplier_d = mplier_q;
    acc_d    = acc_q;
    cnt_d    = cnt_q;
    acc_nxt  = acc_q + (mplier_q[0] ? mcand_q : '0);
`endif
    case (state_q)
`ifdef ALU_MUL_EN
      BUSY: begin
        acc_d    = acc_nxt;
        mcand_d  = mcand_q << 1;
        mplier_d = mplier_q >> 1;
        cnt_d    = cnt_q + SHW'(1);
        if (cnt_q == LAST) begin
          result_d = acc_nxt[WIDTH-1:0];
          flags_d  = {~|acc_nxt[WIDTH-1:0], acc_nxt[WIDTH-1], |acc_nxt[2*WIDTH-1:WIDTH], 1'b0};
          err_d    = 1'b0;
          state_d  = DONE;
        end
      end
`endif
      DONE:    if (out_ready && !in_valid) state_d = IDLE;
      default: ;
    endcase
    if (accept) begin
`ifdef ALU_MUL_EN
      if (alu_mul) begin
        state_d  = BUSY;
        mcand_d  = {{WIDTH{1'b0}}, a};
        mplier_d = b;
        acc_d    = '0;
        cnt_d    = '0;
      end else
`endif
      begin
        state_d  = DONE;
        result_d = alu_res;
        // Reserved opcodes report all-zero flags, not Z=1.
        flags_d  = alu_err ? 4'b0000 : {~|alu_res, alu_res[WIDTH-1], alu_c, alu_v};
        err_d    = alu_err;
      end
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q  <= IDLE;
      result_q <= '0;
      flags_q  <= '0;
      err_q    <= 1'b0;
`ifdef ALU_MUL_EN
      mcand_q  <= '0;
      mplier_q <= '0;
      acc_q    <= '0;
      cnt_q    <= '0;
`endif
    end else begin
      state_q  <= state_d;
      result_q <= result_d;
      flags_q  <= flags_d;
      err_q    <= err_d;
`ifdef ALU_MUL_EN
      mcand_q  <= mcand_d;
      mplier_q <= mplier_d;
      acc_q    <= acc_d;
      cnt_q    <= cnt_d;
`endif
    end
  end

  assign out_valid = (state_q == DONE);
  assign result    = result_q;
  assign flags     = flags_q;
  assign err       = err_q;
endmodule

// File: tb/tb_alu_seq_nb.sv
// Directed table-driven bench for alu_seq_nb at WIDTH=4, plus handshake/MUL/reset sequences.
`timescale 1ns/1ps
module tb_alu_seq_nb;
  logic       clk = 1'b0;
  logic       rst_n;
  logic       in_valid, in_ready, out_valid, out_ready, err;
  logic [3:0] a, b, op, result, flags;
  int         errors = 0;
  int         checks = 0;
  int         n;

  alu_seq_nb #(.WIDTH(4)) dut (
    .clk(clk), .rst_n(rst_n), .in_valid(in_valid), .in_ready(in_ready),
    .a(a), .b(b), .op(op), .out_valid(out_valid), .out_ready(out_ready),
    .result(result), .flags(flags), .err(err)
  );

  always #5 clk = ~clk;

  typedef struct {
    string      nm;
    logic [3:0] op, a, b, res, fl;
    logic       err;
  } vec_t;
  vec_t vt[16];

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h", nm, act, exp);
    end
  endtask

  initial begin
    // flags are {Z,N,C,V}
    vt[0]  = '{"add_3_5",   4'h0, 4'h3, 4'h5, 4'b1000, 4'b0101, 1'b0};
    vt[1]  = '{"sub_2_5",   4'h1, 4'h2, 4'h5, 4'b1101, 4'b0110, 1'b0};
    vt[2]  = '{"sub_5_2",   4'h1, 4'h5, 4'h2, 4'b0011, 4'b0000, 1'b0};
    vt[3]  = '{"shr_5_1",   4'h6, 4'h5, 4'h1, 4'b0010, 4'b0010, 1'b0};
    vt[4]  = '{"shl_5_2",   4'h7, 4'h5, 4'h2, 4'b0100, 4'b0010, 1'b0};
    vt[5]  = '{"add_wrap",  4'h0, 4'hF, 4'h1, 4'b0000, 4'b1010, 1'b0};
    vt[6]  = '{"add_ovf",   4'h0, 4'h7, 4'h1, 4'b1000, 4'b0101, 1'b0};
    vt[7]  = '{"sub_ovf",   4'h1, 4'h8, 4'h1, 4'b0111, 4'b0001, 1'b0};
    vt[8]  = '{"and",       4'h2, 4'hC, 4'hA, 4'b1000, 4'b0100, 1'b0};
    vt[9]  = '{"or_zero",   4'h3, 4'h0, 4'h0, 4'b0000, 4'b1000, 1'b0};
    vt[10] = '{"xor",       4'h4, 4'hF, 4'h5, 4'b1010, 4'b0100, 1'b0};
    vt[11] = '{"not",       4'h5, 4'h5, 4'h0, 4'b1010, 4'b0100, 1'b0};
    vt[12] = '{"shr_by0",   4'h6, 4'h9, 4'h0, 4'b1001, 4'b0100, 1'b0};
    vt[13] = '{"shl_b_3",   4'h7, 4'hB, 4'h3, 4'b1000, 4'b0110, 1'b0};
    vt[14] = '{"shr_8_3",   4'h6, 4'h8, 4'hB, 4'b0001, 4'b0000, 1'b0};
    vt[15] = '{"reserved",  4'hF, 4'h6, 4'h7, 4'b0000, 4'b0000, 1'b1};

    rst_n = 1'b0; in_valid = 1'b0; out_ready = 1'b1; a = '0; b = '0; op = '0;
    repeat (2) @(negedge clk);
    chk("rst_out_valid", out_valid, 0);
    chk("rst_in_ready", in_ready, 1);
    chk("rst_result", result, 0);
    chk("rst_flags", flags, 0);
    chk("rst_err", err, 0);
    rst_n = 1'b1;

    // Back-to-back table: each new op is presented while the previous result is consumed.
    for (int i = 0; i < 16; i++) begin
      @(negedge clk);
      op = vt[i].op; a = vt[i].a; b = vt[i].b; in_valid = 1'b1;
      @(negedge clk);
      chk({vt[i].nm, "_valid"}, out_valid, 1);
      chk({vt[i].nm, "_in_ready"}, in_ready, 1);
      chk({vt[i].nm, "_result"}, result, vt[i].res);
      chk({vt[i].nm, "_flags"}, flags, vt[i].fl);
      chk({vt[i].nm, "_err"}, err, vt[i].err);
      in_valid = 1'b0;
    end
    @(negedge clk);
    chk("drain_idle", out_valid, 0);

    // Backpressure: result held, offered op not taken until out_ready.
    op = 4'h0; a = 4'h1; b = 4'h1; in_valid = 1'b1; out_ready = 1'b0;
    @(negedge clk);
    a = 4'h9; b = 4'h3;
    for (int i = 0; i < 3; i++) begin
      chk("bp_valid", out_valid, 1);
      chk("bp_result", result, 4'b0010);
      chk("bp_in_ready", in_ready, 0);
      @(negedge clk);
    end
    out_ready = 1'b1;
    #1 chk("bp_release_in_ready", in_ready, 1);
    @(negedge clk);
    in_valid = 1'b0;
    chk("bp_next_result", result, 4'b1100);
    chk("bp_next_flags", flags, 4'b0100);
    @(negedge clk);

    // MUL 7*3
    op = 4'h8; a = 4'h7; b = 4'h3; in_valid = 1'b1;
    @(negedge clk);
    n = 1;
    in_valid = 1'b0;
`ifdef ALU_MUL_EN
    chk("mul_busy_in_ready", in_ready, 0);
    chk("mul_busy_valid", out_valid, 0);
    while (!out_valid && n < 20) begin
      @(negedge clk);
      n++;
    end
    chk("mul_latency", n, 5);
    chk("mul_result", result, 4'b0101);
    chk("mul_flags", flags, 4'b0010);
    chk("mul_err", err, 0);
`else
    chk("mul_rsv_valid", out_valid, 1);
    chk("mul_rsv_result", result, 0);
    chk("mul_rsv_flags", flags, 0);
    chk("mul_rsv_err", err, 1);
`endif
    @(negedge clk);

    // Reset two cycles into a MUL aborts it.
    op = 4'h8; a = 4'h7; b = 4'h3; in_valid = 1'b1;
    @(negedge clk);
    in_valid = 1'b0;
    @(negedge clk);
    rst_n = 1'b0;
    #1;
    chk("abort_valid", out_valid, 0);
    chk("abort_in_ready", in_ready, 1);
    chk("abort_result", result, 0);
    @(negedge clk);
    rst_n = 1'b1;
    repeat (6) begin
      @(negedge clk);
      chk("abort_no_partial", out_valid, 0);
    end
    op = 4'h0; a = 4'h4; b = 4'h4; in_valid = 1'b1;
    @(negedge clk);
    in_valid = 1'b0;
    chk("post_rst_valid", out_valid, 1);
    chk("post_rst_result", result, 4'b1000);
    chk("post_rst_flags", flags, 4'b0101);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end
endmodule
